// File: rtl/boot_pkg.sv
// Shared state encoding and default widths for the boot ROM to RAM copier.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    WR_REQ,
    DONE
  } state_t;

  localparam int BOOT_SRC_AW = 4;
  localparam int BOOT_DW     = 16;
  localparam int BOOT_DST_AW = 8;
  localparam int BOOT_WORDS  = 8;

endpackage

// File: rtl/boot_loader.sv
// Copies WORDS ROM words into RAM (3 cycles/word), keeps CPU in reset until done.
// Each cycle without dst_ack in WR_REQ stalls the copy by exactly one cycle.
module boot_loader
  import boot_pkg::*;
#(
  parameter int SRC_AW   = BOOT_SRC_AW,
  parameter int DW       = BOOT_DW,
  parameter int WORDS    = BOOT_WORDS,
  parameter int DST_AW   = BOOT_DST_AW,
  parameter int DST_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              src_cs,
  output logic              src_we,
  output logic [SRC_AW-1:0] src_addr,
  output logic [DW-1:0]     src_din,
  input  logic [DW-1:0]     src_dout,
  output logic              dst_cs,
  output logic              dst_we,
  output logic [DST_AW-1:0] dst_addr,
  output logic [DW-1:0]     dst_wdata,
  input  logic              dst_ack,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [DW-1:0]     checksum
);

  localparam logic [SRC_AW-1:0] LAST_IDX = SRC_AW'(WORDS - 1);
  localparam logic [DST_AW-1:0] BASE     = DST_AW'(DST_BASE);

  state_t            state;
  state_t            state_nxt;
  logic [SRC_AW-1:0] idx;
  logic [DW-1:0]     data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      data_q   <= '0;
      checksum <= '0;
    end else begin
      state <= state_nxt;
      if (state == RD_CAP) begin
        data_q   <= src_dout;
        checksum <= checksum ^ src_dout;
      end
      if (state == WR_REQ && dst_ack && idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Outputs decode from state/idx/data_q only, so no input reaches an output combinationally.
  always_comb begin
    state_nxt = state;
    src_cs    = 1'b0;
    src_we    = 1'b0;
    src_addr  = '0;
    src_din   = '0;
    dst_cs    = 1'b0;
    dst_we    = 1'b0;
    dst_addr  = '0;
    dst_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    cpu_hold  = 1'b1;

    unique case (state)
      IDLE: begin
        if (start) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        src_cs    = 1'b1;
        src_addr  = idx;
        busy      = 1'b1;
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        src_cs    = 1'b1;
        src_addr  = idx;
        busy      = 1'b1;
        state_nxt = WR_REQ;
      end
      WR_REQ: begin
        dst_cs    = 1'b1;
        dst_we    = 1'b1;
        dst_addr  = BASE + DST_AW'(idx);
        dst_wdata = data_q;
        busy      = 1'b1;
        if (dst_ack) state_nxt = (idx == LAST_IDX) ? DONE : RD_REQ;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Bus initiator that copies a boot image out of the boot ROM and writes it word by word into main RAM.
- Holds the CPU in reset until the copy is done.
- Talks to the ROM through its cs/we/addr/din/dout slave port. Drives a simple write-with-ack port into RAM.
- Keeps a running XOR checksum of the copied image so firmware and the bench can check integrity.

Parameters:
- SRC_AW, 4, ROM address width.
- DW, 16, data width of both ports.
- WORDS, 8, words to copy (1..2**SRC_AW). Source addresses run 0..WORDS-1.
- DST_AW, 8, RAM address width.
- DST_BASE, 0, RAM address of the first copied word.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low; sampled on the clk rising edge
- start  in  1  level; sampled only in IDLE
- src_cs  out  1  ROM chip select
- src_we  out  1  ROM write enable; always 0
- src_addr  out  SRC_AW  ROM word address
- src_din  out  DW  ROM write data; always 0
- src_dout  in  DW  ROM read data; valid while src_cs=1 and src_we=0
- dst_cs  out  1  RAM chip select
- dst_we  out  1  RAM write enable
- dst_addr  out  DST_AW  RAM word address
- dst_wdata  out  DW  RAM write data
- dst_ack  in  1  RAM accepted the write this cycle
- busy  out  1  copy in progress
- done  out  1  copy finished; sticky until reset
- cpu_hold  out  1  holds the CPU in reset
- checksum  out  DW  XOR of all words copied so far

Behaviour:
- Reset (rst_n=0 at a clk edge) gives:
  - state=IDLE, idx=0, data_q=0, checksum=0;
  - all cs/we/addr/wdata outputs 0;
  - busy=0, done=0, cpu_hold=1.
- Reset mid-copy aborts immediately, with the same values. RAM contents already written are left as they are.
- IDLE:
  - If start=1 at an edge, the next state is RD_REQ.
  - Otherwise stay in IDLE. cpu_hold stays 1.
- RD_REQ: src_cs=1, src_we=0, src_addr=idx, busy=1. Next state is RD_CAP.
- RD_CAP:
  - src_cs stays 1 and src_addr=idx, so the ROM output latch is held transparent.
  - At the edge: data_q<=src_dout, checksum<=checksum^src_dout.
  - Next state is WR_REQ.
- WR_REQ:
  - dst_cs=1, dst_we=1, dst_addr=(DST_BASE+idx) mod 2**DST_AW (wrap, no error), dst_wdata=data_q.
  - Hold all of these stable until dst_ack=1 at an edge. The wait is unbounded.
  - On ack with idx=WORDS-1: next state is DONE.
  - On ack otherwise: idx<=idx+1, next state is RD_REQ.
- dst_ack outside WR_REQ is ignored.
- DONE: done=1, busy=0, cpu_hold=0, all bus outputs 0, checksum frozen. start is ignored. Only reset leaves DONE.
- cs and we are never asserted on both ports in the same cycle.
- Latency with dst_ack tied 1: 3 cycles per word. done rises 3*WORDS edges after the edge that sampled start.
- Each dst_ack wait cycle adds exactly one cycle.
- All outputs are registered or decoded from state/idx only. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package boot_pkg:
  - state enum {IDLE, RD_REQ, RD_CAP, WR_REQ, DONE};
  - default widths SRC_AW/DW/DST_AW;
  - BOOT_WORDS constant shared with the ROM image.
- No sub-module. Checksum accumulator and index counter stay inline.

Test Plan:
- Boot image: ROM loaded with F200,4000,F800,1007,F400,3008,4000,0000.
- Full copy, dst_ack tied 1:
  - Stimulus: reset, then start pulse.
  - RAM[0..7] equals the image.
  - done=1 and cpu_hold=0 exactly 24 cycles after the start edge.
  - checksum=16'hDE0F.
- Backpressure:
  - Stimulus: dst_ack low for 3 cycles on word 3.
  - dst_addr=3 and dst_wdata=1007 stay stable during the wait.
  - done is 3 cycles later than in the full-copy case (27). Contents are identical.
- Reset mid-copy:
  - Stimulus: rst_n=0 for one edge while in WR_REQ of word 4.
  - Next cycle: all outputs at reset values, checksum=0, cpu_hold=1.
  - A new start yields a correct full copy.
- Start ignored in DONE: pulse start after done=1 -> no further src_cs or dst_cs activity; checksum stays DE0F.
- Address wrap: DST_BASE=8'hFE -> words land at FE, FF, 00..05.
- Protocol monitor (all tests):
  - src_we is never 1.
  - src_cs and dst_cs are never high together.
  - start held high in IDLE before reset release causes no activity until rst_n=1.
